button_debouncer: RTL and testbench
===================================

// Module: button_debouncer
// PURPOSE
//  Multi-channel debouncer with press/release/long-press event generation.
//  Sits between the 2-stage input synchronizer on {btn,sw} and the edge detector / user logic.
//  Rejects contact bounce shorter than DEBOUNCE_CYCLES and emits clean levels and one-cycle event pulses.
//  Inputs must already be synchronized to clk125; no internal synchronizer.
// PARAMETERS
//  WIDTH              6          number of independent channels
//  DEBOUNCE_CYCLES    1250000    stable samples required to accept a change (10 ms @125 MHz); legal >= 2
//  LONG_PRESS_CYCLES  125000000  cycles in stable-high before long_press fires (1 s); legal >= 2
// PORTS
//  clk125      in   1      system clock, 125 MHz
//  nrst        in   1      synchronous reset, active-low
//  in          in   WIDTH  synchronized raw button/switch levels
//  out         out  WIDTH  debounced level
//  rise        out  WIDTH  one-cycle pulse when out goes 0->1
//  fall        out  WIDTH  one-cycle pulse when out goes 1->0
//  long_press  out  WIDTH  one-cycle pulse once per press after LONG_PRESS_CYCLES held
// BEHAVIOUR
//  - Reset (nrst=0 at edge): all outputs 0, every channel -> ST_LO, counters 0.
//    Reset mid-operation abandons any pending change; out drops with NO fall pulse.
//  - Per-channel FSM, all outputs registered:
//    ST_LO:   in=1 -> ST_WAIT_HI, cnt<=0.
//    ST_WAIT_HI: in=0 -> ST_LO (glitch rejected, no output change); in=1 -> cnt++;
//             in=1 && cnt==DEBOUNCE_CYCLES-1 -> ST_HI, out<=1, rise<=1.
//    ST_HI:   in=0 -> ST_WAIT_LO, cnt<=0.
//    ST_WAIT_LO: in=1 -> ST_HI (glitch rejected); in=0 -> cnt++;
//             in=0 && cnt==DEBOUNCE_CYCLES-1 -> ST_LO, out<=0, fall<=1.
//  - Latency: out changes on the edge sampling the (DEBOUNCE_CYCLES+1)th consecutive equal sample.
//  - rise/fall are high exactly one cycle, aligned with the out transition; never both high on one channel.
//  - cnt width $clog2(DEBOUNCE_CYCLES); never wraps (state leaves at terminal count).
//  - Channels fully independent; simultaneous events on several channels all reported in the same cycle.
// CONFIGURATION
//  - Macro BUTTON_DEBOUNCER_LONG_PRESS_EN:
//    defined: per-channel hold counter ($clog2(LONG_PRESS_CYCLES) bits) cleared on entry to ST_HI,
//      increments in ST_HI and ST_WAIT_LO; at hold==LONG_PRESS_CYCLES-1 long_press pulses one cycle,
//      then the counter saturates (no repeat) until the next entry into ST_HI.
//      A bounce back ST_WAIT_LO->ST_HI does not clear it. Cleared by reset.
//    undefined: port kept, long_press tied to '0, hold counter not synthesized.
// STRUCTURE
//  - Package button_debouncer_pkg: typedef enum logic [1:0] {ST_LO,ST_WAIT_HI,ST_HI,ST_WAIT_LO} db_state_t.
//  - Sub-module debounce_channel: one FSM + counters per bit, instantiated WIDTH times via generate.
//  - Top level only packs/unpacks vectors and checks parameters (elaboration $error if < 2).
// TESTING (bench params: WIDTH=6, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10)
//  1. in[0] 0->1 held 10 cycles -> out[0] goes 1 on 5th sampling edge; rise[0]=1 for exactly that cycle.
//  2. in[1] high 3 cycles then low; repeated 5 times -> out[1], rise[1], fall[1] stay 0.
//  3. out[2]=1, in[2] low 2 cycles, high 1, low 5 -> single fall[2] pulse at 5th low sample of final run.
//  4. in[3] held high 30 cycles -> long_press[3] one pulse 10 cycles after rise[3], none after;
//     without the macro long_press stays 0.
//  5. nrst=0 while ch0 in ST_WAIT_HI and ch1 in ST_HI -> all outputs 0 next edge, no fall;
//     after release with in high, out rises only after a full 4-cycle debounce.
//  6. in=6'b111111 at the same edge -> rise=6'b111111 in one cycle; later in=0 -> fall=6'b111111 together.

Source files
------------

// File: rtl/button_debouncer_pkg.sv
// Shared types and constants for the button_debouncer slice.
// The optional long-press logic is enabled by defining BUTTON_DEBOUNCER_LONG_PRESS_EN.
package button_debouncer_pkg;

    typedef enum logic [1:0] {
        ST_LO,
        ST_WAIT_HI,
        ST_HI,
        ST_WAIT_LO
    } db_state_t;

    // Smallest legal value for either cycle-count parameter.
    localparam int unsigned DB_MIN_CYCLES = 2;

endpackage

// File: rtl/button_debouncer_channel.sv
// Single-bit debounce FSM with registered level, edge pulses and optional long-press pulse.
// Long-press hold counter exists only when BUTTON_DEBOUNCER_LONG_PRESS_EN is defined.
module debounce_channel
    import button_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = 1250000,
    parameter int unsigned LONG_PRESS_CYCLES = 125000000
) (
    input  logic clk125,
    input  logic nrst,
    input  logic in,
    output logic out,
    output logic rise,
    output logic fall,
    output logic long_press
);

    localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    db_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             out_nxt, rise_nxt, fall_nxt;

    always_ff @(posedge clk125) begin
        if (!nrst) begin
            state <= ST_LO;
            cnt   <= '0;
            out   <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            out   <= out_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        out_nxt   = out;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            ST_LO: begin
                if (in) begin
                    state_nxt = ST_WAIT_HI;
                    cnt_nxt   = '0;
                end
            end
            ST_WAIT_HI: begin
                if (!in) begin
                    state_nxt = ST_LO;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_HI;
                    cnt_nxt   = '0;
                    out_nxt   = 1'b1;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_HI: begin
                if (!in) begin
                    state_nxt = ST_WAIT_LO;
                    cnt_nxt   = '0;
                end
            end
            ST_WAIT_LO: begin
                if (in) begin
                    state_nxt = ST_HI;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_LO;
                    cnt_nxt   = '0;
                    out_nxt   = 1'b0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_LO;
                cnt_nxt   = '0;
            end
        endcase
    end

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    localparam int unsigned      HOLD_W    = $clog2(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    logic [HOLD_W-1:0] hold, hold_nxt;
    logic              hold_done, hold_done_nxt;
    logic              long_press_nxt;

    always_ff @(posedge clk125) begin
        if (!nrst) begin
            hold       <= '0;
            hold_done  <= 1'b0;
            long_press <= 1'b0;
        end else begin
            hold       <= hold_nxt;
            hold_done  <= hold_done_nxt;
            long_press <= long_press_nxt;
        end
    end

    // hold_done latches after the pulse so the counter saturates without re-firing;
    // only a debounced rise (WAIT_HI->HI) rearms it, not a bounce back from WAIT_LO.
    always_comb begin
        hold_nxt       = hold;
        hold_done_nxt  = hold_done;
        long_press_nxt = 1'b0;
        if (state == ST_WAIT_HI && state_nxt == ST_HI) begin
            hold_nxt      = '0;
            hold_done_nxt = 1'b0;
        end else if ((state == ST_HI || state == ST_WAIT_LO) && !hold_done) begin
            if (hold == HOLD_LAST) begin
                long_press_nxt = 1'b1;
                hold_done_nxt  = 1'b1;
            end else begin
                hold_nxt = hold + HOLD_W'(1);
            end
        end
    end
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel debouncer top: parameter checks and per-bit channel instances.
// Define BUTTON_DEBOUNCER_LONG_PRESS_EN to enable long_press; otherwise it is tied low.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int unsigned WIDTH             = 6,
    parameter int unsigned DEBOUNCE_CYCLES   = 1250000,
    parameter int unsigned LONG_PRESS_CYCLES = 125000000
) (
    input  logic             clk125,
    input  logic             nrst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] long_press
);

    if (DEBOUNCE_CYCLES < DB_MIN_CYCLES) begin : g_bad_debounce
        $error("button_debouncer: DEBOUNCE_CYCLES must be >= 2");
    end
    if (LONG_PRESS_CYCLES < DB_MIN_CYCLES) begin : g_bad_long_press
        $error("button_debouncer: LONG_PRESS_CYCLES must be >= 2");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
        ) u_ch (
            .clk125    (clk125),
            .nrst      (nrst),
            .in        (in[i]),
            .out       (out[i]),
            .rise      (rise[i]),
            .fall      (fall[i]),
            .long_press(long_press[i])
        );
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: vector table, corner sequences, randomized run vs model.
// Long-press expectations follow BUTTON_DEBOUNCER_LONG_PRESS_EN.
module tb_button_debouncer;

    localparam int W  = 6;
    localparam int DB = 4;
    localparam int LP = 10;
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif

    logic         clk125 = 1'b0;
    logic         nrst;
    logic [W-1:0] in_v;
    logic [W-1:0] out, rise, fall, long_press;

    button_debouncer #(
        .WIDTH            (W),
        .DEBOUNCE_CYCLES  (DB),
        .LONG_PRESS_CYCLES(LP)
    ) dut (
        .clk125    (clk125),
        .nrst      (nrst),
        .in        (in_v),
        .out       (out),
        .rise      (rise),
        .fall      (fall),
        .long_press(long_press)
    );

    always #4 clk125 = ~clk125;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: out flips once DB+1 consecutive samples disagree with it.
    int           run   [W];
    int           since [W];
    bit           fired [W];
    logic [W-1:0] m_out, m_rise, m_fall, m_lp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_step(input logic [W-1:0] v, input logic r);
        m_rise = '0;
        m_fall = '0;
        m_lp   = '0;
        if (!r) begin
            m_out = '0;
            for (int c = 0; c < W; c++) begin
                run[c] = 0; since[c] = 0; fired[c] = 1'b0;
            end
        end else begin
            for (int c = 0; c < W; c++) begin
                if (m_out[c]) begin
                    since[c]++;
                    if (LP_EN && since[c] == LP && !fired[c]) begin
                        m_lp[c]  = 1'b1;
                        fired[c] = 1'b1;
                    end
                end
                if (v[c] != m_out[c]) begin
                    run[c]++;
                    if (run[c] == DB + 1) begin
                        run[c] = 0;
                        if (!m_out[c]) begin
                            m_rise[c] = 1'b1; since[c] = 0; fired[c] = 1'b0;
                        end else begin
                            m_fall[c] = 1'b1;
                        end
                        m_out[c] = ~m_out[c];
                    end
                end else begin
                    run[c] = 0;
                end
            end
        end
    endtask

    task automatic tick(input logic [W-1:0] v, input logic r);
        @(negedge clk125);
        in_v = v;
        nrst = r;
        @(posedge clk125);
        model_step(v, r);
        #1;
        chk("model", 32'({out, rise, fall, long_press}), 32'({m_out, m_rise, m_fall, m_lp}));
    endtask

    typedef struct {
        logic [W-1:0] in;
        logic [W-1:0] out;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [W-1:0] i, input logic [W-1:0] o,
                                input logic [W-1:0] r, input logic [W-1:0] f);
        vec_t v;
        v.in = i; v.out = o; v.rise = r; v.fall = f;
        return v;
    endfunction

    initial begin
        logic [W-1:0] cur;
        logic         rr;

        in_v  = '0;
        nrst  = 1'b0;
        m_out = '0;
        tick('0, 1'b0);
        tick('0, 1'b0);
        chk("reset_state", 32'({out, rise, fall, long_press}), 32'd0);

        // ch0 rise on 5th sample then fall; then all channels rise and fall together
        for (int i = 0; i < 4; i++)  tbl.push_back(mk(6'h01, 6'h00, 6'h00, 6'h00));
        tbl.push_back(mk(6'h01, 6'h01, 6'h01, 6'h00));
        for (int i = 0; i < 5; i++)  tbl.push_back(mk(6'h01, 6'h01, 6'h00, 6'h00));
        for (int i = 0; i < 4; i++)  tbl.push_back(mk(6'h00, 6'h01, 6'h00, 6'h00));
        tbl.push_back(mk(6'h00, 6'h00, 6'h00, 6'h01));
        tbl.push_back(mk(6'h00, 6'h00, 6'h00, 6'h00));
        for (int i = 0; i < 4; i++)  tbl.push_back(mk(6'h3f, 6'h00, 6'h00, 6'h00));
        tbl.push_back(mk(6'h3f, 6'h3f, 6'h3f, 6'h00));
        tbl.push_back(mk(6'h3f, 6'h3f, 6'h00, 6'h00));
        for (int i = 0; i < 4; i++)  tbl.push_back(mk(6'h00, 6'h3f, 6'h00, 6'h00));
        tbl.push_back(mk(6'h00, 6'h00, 6'h00, 6'h3f));
        tbl.push_back(mk(6'h00, 6'h00, 6'h00, 6'h00));
        for (int i = 0; i < tbl.size(); i++) begin
            tick(tbl[i].in, 1'b1);
            chk($sformatf("tbl[%0d]", i), 32'({out, rise, fall}),
                32'({tbl[i].out, tbl[i].rise, tbl[i].fall}));
        end

        // short bursts on ch1 never get through
        for (int rep = 0; rep < 5; rep++) begin
            for (int k = 0; k < 4; k++) begin
                tick((k < 3) ? 6'h02 : 6'h00, 1'b1);
                chk("t2_ch1_quiet", 32'({out[1], rise[1], fall[1]}), 32'd0);
            end
        end

        // ch2 release with a bounce: fall only at 5th sample of the final low run
        for (int k = 0; k < 6; k++) tick(6'h04, 1'b1);
        chk("t3_ch2_high", 32'(out[2]), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick((k == 2) ? 6'h04 : 6'h00, 1'b1);
            chk("t3_bounce", 32'({out[2], fall[2]}), 32'b10);
        end
        for (int k = 0; k < 7; k++) begin
            tick(6'h00, 1'b1);
            chk("t3_fall", 32'({out[2], fall[2]}), 32'({(k < 4) ? 1'b1 : 1'b0, (k == 4) ? 1'b1 : 1'b0}));
        end

        // ch3 held 30 cycles: rise at sample 5, long_press 10 cycles later, once
        for (int k = 0; k < 30; k++) begin
            tick(6'h08, 1'b1);
            chk("t4_long", 32'({rise[3], long_press[3]}),
                32'({(k == 4) ? 1'b1 : 1'b0, (LP_EN && k == 14) ? 1'b1 : 1'b0}));
        end
        for (int k = 0; k < 6; k++) tick(6'h00, 1'b1);
        chk("t4_released", 32'(out[3]), 32'd0);

        // reset with ch1 high and ch0 mid-debounce
        for (int k = 0; k < 6; k++) tick(6'h02, 1'b1);
        tick(6'h03, 1'b1);
        tick(6'h03, 1'b1);
        chk("t5_pre", 32'(out[1:0]), 32'b10);
        tick(6'h03, 1'b0);
        chk("t5_reset", 32'({out, rise, fall, long_press}), 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick(6'h03, 1'b1);
            chk("t5_redebounce", 32'({out, rise, fall}),
                32'({(k >= 4) ? 6'h03 : 6'h00, (k == 4) ? 6'h03 : 6'h00, 6'h00}));
        end
        for (int k = 0; k < 6; k++) tick(6'h00, 1'b1);

        // randomized run: each channel toggles rarely, so both glitches and long holds occur
        cur = '0;
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < W; c++)
                if ($urandom_range(0, 11) == 0) cur[c] = ~cur[c];
            rr = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
            tick(cur, rr);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
